mem_access: RTL and testbench

- Memory-access stage between the execute stage and the mem/wb pipeline register.
- Issues load/store/LL/SC requests on the data SRAM-like bus with an addr_ok/data_ok handshake.
- Aligns and extends load data, detects misalignment (ALE) and evaluates SC success from LLbit.
- Presents one registered result per instruction and requests a pipeline stall while a memory transaction is outstanding.

---
 rtl/mem_access.sv | 212 +++++++++++++++++++++
 tb/tb_mem_access.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access stage: issues load/store/LL/SC on an addr_ok/data_ok bus,
// aligns load data, flags misaligned accesses and registers one result per instruction.
module mem_access #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [3:0]        ex_mem_op,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [ADDR_W-1:0] ex_store_data,
    input  logic [4:0]        ex_wd,
    input  logic              ex_wreg,
    input  logic [ADDR_W-1:0] ex_wdata,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic              LLbit_i,
    input  logic              flush,
    output logic              data_req,
    output logic              data_wr,
    output logic [3:0]        data_wstrb,
    output logic [ADDR_W-1:0] data_addr,
    output logic [ADDR_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [ADDR_W-1:0] data_rdata,
    output logic              stall_req,
    output logic              mem_valid,
    output logic [4:0]        mem_wd,
    output logic              mem_wreg,
    output logic [ADDR_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] mem_inst_pc,
    output logic              mem_LLbit_we,
    output logic              mem_LLbit_value,
    output logic              mem_excp
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_e;

    localparam logic [3:0] OP_LD_B  = 4'd1, OP_LD_H  = 4'd2, OP_LD_W = 4'd3,
                           OP_LD_BU = 4'd4, OP_LD_HU = 4'd5, OP_ST_B = 4'd6,
                           OP_ST_H  = 4'd7, OP_ST_W  = 4'd8, OP_LL_W = 4'd9,
                           OP_SC_W  = 4'd10;

    state_e              state_q, state_d;
    logic                capture;
    logic [3:0]          op_q;
    logic [ADDR_W-1:0]   addr_q, sdata_q, pc_q;
    logic [4:0]          wd_q;
    logic                wreg_q;

    logic                valid_q, valid_d, wreg_o_q, wreg_o_d;
    logic [4:0]          wd_o_q, wd_o_d;
    logic [ADDR_W-1:0]   wdata_o_q, wdata_o_d, pc_o_q, pc_o_d;
    logic                llwe_q, llwe_d, llval_q, llval_d, excp_q, excp_d;

    logic ex_byte, ex_half, ex_word, ex_mem, ex_misal, ex_sc_fail;
    logic q_store;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [ADDR_W-1:0] ld_val;

    always_comb begin
        ex_byte    = (ex_mem_op == OP_LD_B) || (ex_mem_op == OP_LD_BU) || (ex_mem_op == OP_ST_B);
        ex_half    = (ex_mem_op == OP_LD_H) || (ex_mem_op == OP_LD_HU) || (ex_mem_op == OP_ST_H);
        ex_word    = (ex_mem_op == OP_LD_W) || (ex_mem_op == OP_ST_W)  ||
                     (ex_mem_op == OP_LL_W) || (ex_mem_op == OP_SC_W);
        ex_mem     = ex_byte || ex_half || ex_word;
        ex_misal   = (ex_half && ex_addr[0]) || (ex_word && (ex_addr[1:0] != 2'b00));
        ex_sc_fail = (ex_mem_op == OP_SC_W) && !LLbit_i;
        q_store    = (op_q == OP_ST_B) || (op_q == OP_ST_H) || (op_q == OP_ST_W);
    end

    always_comb begin
        ld_byte = data_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (op_q)
            OP_LD_B:          ld_val = {{24{ld_byte[7]}}, ld_byte};
            OP_LD_BU:         ld_val = {24'd0, ld_byte};
            OP_LD_H:          ld_val = {{16{ld_half[15]}}, ld_half};
            OP_LD_HU:         ld_val = {16'd0, ld_half};
            OP_LD_W, OP_LL_W: ld_val = data_rdata;
            OP_SC_W:          ld_val = 32'd1;
            default:          ld_val = '0;
        endcase
    end

    always_comb begin
        data_req   = (state_q == REQ);
        data_wr    = data_req && (q_store || (op_q == OP_SC_W));
        data_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        data_wstrb = 4'b0000;
        data_wdata = sdata_q;
        case (op_q)
            OP_ST_B: begin
                data_wstrb = 4'b0001 << addr_q[1:0];
                data_wdata = {4{sdata_q[7:0]}};
            end
            OP_ST_H: begin
                data_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
                data_wdata = {2{sdata_q[15:0]}};
            end
            OP_ST_W, OP_SC_W: data_wstrb = 4'b1111;
            default: ;
        endcase
        if (!data_req) data_wstrb = 4'b0000;
        stall_req = (state_q == REQ) || ((state_q == WAIT) && !data_data_ok) || (state_q == DRAIN);
    end

    // mem_valid defaults low every cycle, so any flush edge naturally suppresses it
    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        valid_d   = 1'b0;
        wd_o_d    = wd_o_q;
        wreg_o_d  = wreg_o_q;
        wdata_o_d = wdata_o_q;
        pc_o_d    = pc_o_q;
        llwe_d    = llwe_q;
        llval_d   = llval_q;
        excp_d    = excp_q;
        case (state_q)
            IDLE: begin
                if (ex_valid && !flush) begin
                    if (ex_mem && !ex_misal && !ex_sc_fail) begin
                        state_d = REQ;
                        capture = 1'b1;
                    end else begin
                        valid_d   = 1'b1;
                        wd_o_d    = ex_wd;
                        pc_o_d    = ex_pc;
                        llwe_d    = 1'b0;
                        llval_d   = 1'b0;
                        excp_d    = ex_mem && ex_misal;
                        wreg_o_d  = (ex_mem && ex_misal) ? 1'b0 : ex_wreg;
                        wdata_o_d = !ex_mem ? ex_wdata : (ex_misal ? ex_addr : '0);
                    end
                end
            end
            REQ: begin
                if (flush)             state_d = data_addr_ok ? DRAIN : IDLE;
                else if (data_addr_ok) state_d = WAIT;
            end
            WAIT: begin
                if (data_data_ok) begin
                    state_d = IDLE;
                    if (!flush) begin
                        valid_d   = 1'b1;
                        wd_o_d    = wd_q;
                        pc_o_d    = pc_q;
                        excp_d    = 1'b0;
                        wreg_o_d  = q_store ? 1'b0 : wreg_q;
                        wdata_o_d = ld_val;
                        llwe_d    = (op_q == OP_LL_W) || (op_q == OP_SC_W);
                        llval_d   = (op_q == OP_LL_W);
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (data_data_ok) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            sdata_q   <= '0;
            pc_q      <= '0;
            wd_q      <= '0;
            wreg_q    <= 1'b0;
            valid_q   <= 1'b0;
            wd_o_q    <= '0;
            wreg_o_q  <= 1'b0;
            wdata_o_q <= '0;
            pc_o_q    <= '0;
            llwe_q    <= 1'b0;
            llval_q   <= 1'b0;
            excp_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            if (capture) begin
                op_q    <= ex_mem_op;
                addr_q  <= ex_addr;
                sdata_q <= ex_store_data;
                pc_q    <= ex_pc;
                wd_q    <= ex_wd;
                wreg_q  <= ex_wreg;
            end
            valid_q   <= valid_d;
            wd_o_q    <= wd_o_d;
            wreg_o_q  <= wreg_o_d;
            wdata_o_q <= wdata_o_d;
            pc_o_q    <= pc_o_d;
            llwe_q    <= llwe_d;
            llval_q   <= llval_d;
            excp_q    <= excp_d;
        end
    end

    assign mem_valid       = valid_q;
    assign mem_wd          = wd_o_q;
    assign mem_wreg        = wreg_o_q;
    assign mem_wdata       = wdata_o_q;
    assign mem_inst_pc     = pc_o_q;
    assign mem_LLbit_we    = llwe_q;
    assign mem_LLbit_value = llval_q;
    assign mem_excp        = excp_q;
endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: fixed vector table, randomized ops against a reference model,
// and hand-written flush/reset/back-to-back sequences.
module tb_mem_access;
    logic        clk = 1'b0, rst;
    logic        ex_valid, ex_wreg, LLbit_i, flush;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_addr, ex_store_data, ex_wdata, ex_pc;
    logic [4:0]  ex_wd;
    logic        data_req, data_wr, data_addr_ok, data_data_ok, stall_req;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_valid, mem_wreg, mem_LLbit_we, mem_LLbit_value, mem_excp;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata, mem_inst_pc;

    mem_access dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_mem_op(ex_mem_op), .ex_addr(ex_addr),
        .ex_store_data(ex_store_data), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_pc(ex_pc), .LLbit_i(LLbit_i), .flush(flush), .data_req(data_req), .data_wr(data_wr),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .stall_req(stall_req), .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
        .mem_wdata(mem_wdata), .mem_inst_pc(mem_inst_pc), .mem_LLbit_we(mem_LLbit_we),
        .mem_LLbit_value(mem_LLbit_value), .mem_excp(mem_excp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        bus, wr;
        logic [3:0]  wstrb;
        logic [31:0] bwdata, wdata;
        logic        wreg, excp, llwe, llval;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr, sdata, alu, rdata;
        logic [4:0]  wd;
        logic        wreg, llbit;
        int          a_dly, d_dly;
        exp_t        e;
    } vec_t;

    int          n_pass = 0, n_tot = 0;
    logic [31:0] pc_ctr = 32'h1c00_0000;
    vec_t        tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    function automatic exp_t mkexp(input logic bus, wr, input logic [3:0] wstrb,
                                   input logic [31:0] bwdata, wdata,
                                   input logic wreg, excp, llwe, llval);
        exp_t e;
        e.bus = bus; e.wr = wr; e.wstrb = wstrb; e.bwdata = bwdata; e.wdata = wdata;
        e.wreg = wreg; e.excp = excp; e.llwe = llwe; e.llval = llval;
        return e;
    endfunction

    function automatic vec_t mkv(input logic [3:0] op, input logic [31:0] addr, sdata, alu, rdata,
                                 input logic [4:0] wd, input logic wreg, llbit,
                                 input int a_dly, d_dly, input exp_t e);
        vec_t v;
        v.op = op; v.addr = addr; v.sdata = sdata; v.alu = alu; v.rdata = rdata;
        v.wd = wd; v.wreg = wreg; v.llbit = llbit; v.a_dly = a_dly; v.d_dly = d_dly; v.e = e;
        return v;
    endfunction

    // Reference: access size, lane offset and arithmetic shifts/masks
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] addr, sdata, alu, rdata,
                                   input logic wreg, llbit);
        exp_t e;
        int sz, off;
        bit ld, sgn;
        longint unsigned v;
        e = mkexp(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 0);
        sz = 0; ld = 0; sgn = 0;
        case (op)
            4'd1: begin sz = 1; ld = 1; sgn = 1; end
            4'd2: begin sz = 2; ld = 1; sgn = 1; end
            4'd3: begin sz = 4; ld = 1; end
            4'd4: begin sz = 1; ld = 1; end
            4'd5: begin sz = 2; ld = 1; end
            4'd6: sz = 1;
            4'd7: sz = 2;
            4'd8: sz = 4;
            4'd9: begin sz = 4; ld = 1; end
            4'd10: sz = 4;
            default: sz = 0;
        endcase
        off = int'(addr[1:0]);
        if (sz == 0) begin
            e.wdata = alu; e.wreg = wreg;
        end else if (off % sz != 0) begin
            e.excp = 1; e.wdata = addr; e.wreg = 0;
        end else if (op == 4'd10 && !llbit) begin
            e.wdata = 0; e.wreg = wreg;
        end else begin
            e.bus = 1;
            if (ld) begin
                v = (longint'(rdata) >> (8 * off)) & ((64'd1 << (8 * sz)) - 64'd1);
                if (sgn && v[8 * sz - 1]) v = v - (64'd1 << (8 * sz));
                e.wdata = v[31:0];
                e.wreg  = wreg;
                if (op == 4'd9) begin e.llwe = 1; e.llval = 1; end
            end else begin
                e.wr     = 1;
                e.wstrb  = 4'(((1 << sz) - 1) << off);
                e.bwdata = (sz == 1) ? (sdata & 32'hFF) * 32'h0101_0101 :
                           (sz == 2) ? (sdata & 32'hFFFF) * 32'h0001_0001 : sdata;
                if (op == 4'd10) begin
                    e.wdata = 1; e.wreg = wreg; e.llwe = 1; e.llval = 0;
                end else begin
                    e.wreg = 0;
                end
            end
        end
        return e;
    endfunction

    // Called just after a negedge; returns just after a negedge.
    task automatic run_op(input vec_t v, input string nm);
        logic [31:0] pc;
        pc_ctr = pc_ctr + 32'd4;
        pc = pc_ctr;
        ex_valid = 1; ex_mem_op = v.op; ex_addr = v.addr; ex_store_data = v.sdata;
        ex_wd = v.wd; ex_wreg = v.wreg; ex_wdata = v.alu; ex_pc = pc; LLbit_i = v.llbit;
        @(negedge clk);
        ex_valid = 0;
        if (v.e.bus) begin
            for (int i = 0; i < v.a_dly; i++) begin
                chk({nm, ".req_hold"}, 32'(data_req), 32'd1);
                chk({nm, ".stall_req"}, 32'(stall_req), 32'd1);
                @(negedge clk);
            end
            chk({nm, ".req"}, 32'(data_req), 32'd1);
            chk({nm, ".addr"}, data_addr, {v.addr[31:2], 2'b00});
            chk({nm, ".wr"}, 32'(data_wr), 32'(v.e.wr));
            chk({nm, ".wstrb"}, 32'(data_wstrb), 32'(v.e.wstrb));
            if (v.e.wr) chk({nm, ".bus_wdata"}, data_wdata, v.e.bwdata);
            data_addr_ok = 1;
            @(negedge clk);
            data_addr_ok = 0;
            chk({nm, ".req_drop"}, 32'(data_req), 32'd0);
            for (int i = 1; i < v.d_dly; i++) begin
                chk({nm, ".stall_wait"}, 32'(stall_req), 32'd1);
                chk({nm, ".no_early_valid"}, 32'(mem_valid), 32'd0);
                @(negedge clk);
            end
            data_data_ok = 1; data_rdata = v.rdata;
            #1 chk({nm, ".stall_at_ok"}, 32'(stall_req), 32'd0);
            @(negedge clk);
            data_data_ok = 0; data_rdata = $urandom;
        end else begin
            chk({nm, ".no_req"}, 32'(data_req), 32'd0);
        end
        chk({nm, ".valid"}, 32'(mem_valid), 32'd1);
        chk({nm, ".stall_done"}, 32'(stall_req), 32'd0);
        chk({nm, ".wd"}, 32'(mem_wd), 32'(v.wd));
        chk({nm, ".wreg"}, 32'(mem_wreg), 32'(v.e.wreg));
        chk({nm, ".pc"}, mem_inst_pc, pc);
        chk({nm, ".excp"}, 32'(mem_excp), 32'(v.e.excp));
        chk({nm, ".llwe"}, 32'(mem_LLbit_we), 32'(v.e.llwe));
        chk({nm, ".llval"}, 32'(mem_LLbit_value), 32'(v.e.llval));
        if (!(v.e.bus && v.e.wr && v.op != 4'd10)) chk({nm, ".wdata"}, mem_wdata, v.e.wdata);
        @(negedge clk);
        chk({nm, ".pulse"}, 32'(mem_valid), 32'd0);
    endtask

    task automatic start_ldw(input logic [31:0] addr);
        ex_valid = 1; ex_mem_op = 4'd3; ex_addr = addr; ex_wreg = 1; ex_wd = 5'd7;
        @(negedge clk);
        ex_valid = 0;
    endtask

    initial begin
        vec_t v;
        rst = 1; ex_valid = 0; ex_mem_op = 0; ex_addr = 0; ex_store_data = 0; ex_wd = 0;
        ex_wreg = 0; ex_wdata = 0; ex_pc = 0; LLbit_i = 0; flush = 0;
        data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
        #12;
        chk("rst.data_req", 32'(data_req), 32'd0);
        chk("rst.stall", 32'(stall_req), 32'd0);
        chk("rst.valid", 32'(mem_valid), 32'd0);
        chk("rst.wdata", mem_wdata, 32'd0);
        chk("rst.wstrb", 32'(data_wstrb), 32'd0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        // op, addr, sdata, alu, rdata, wd, wreg, llbit, a_dly, d_dly, {bus,wr,wstrb,bwdata,wdata,wreg,excp,llwe,llval}
        tbl.push_back(mkv(4'd0, 32'h0, 32'h0, 32'h1234, 32'h0, 5'd5, 1, 0, 0, 1,
                          mkexp(0, 0, 4'h0, 32'h0, 32'h1234, 1, 0, 0, 0)));
        tbl.push_back(mkv(4'd1, 32'h1003, 32'h0, 32'h0, 32'h80FF_FFFF, 5'd6, 1, 0, 2, 3,
                          mkexp(1, 0, 4'h0, 32'h0, 32'hFFFF_FF80, 1, 0, 0, 0)));
        tbl.push_back(mkv(4'd4, 32'h1003, 32'h0, 32'h0, 32'h80FF_FFFF, 5'd6, 1, 0, 2, 3,
                          mkexp(1, 0, 4'h0, 32'h0, 32'h0000_0080, 1, 0, 0, 0)));
        tbl.push_back(mkv(4'd7, 32'h2002, 32'hABCD_1234, 32'h0, 32'h0, 5'd8, 1, 0, 1, 1,
                          mkexp(1, 1, 4'b1100, 32'h1234_1234, 32'h0, 0, 0, 0, 0)));
        tbl.push_back(mkv(4'd3, 32'h3001, 32'h0, 32'h0, 32'h0, 5'd9, 1, 0, 0, 1,
                          mkexp(0, 0, 4'h0, 32'h0, 32'h3001, 0, 1, 0, 0)));
        tbl.push_back(mkv(4'd10, 32'h4000, 32'h55, 32'h0, 32'h0, 5'd10, 1, 0, 0, 1,
                          mkexp(0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 0)));
        tbl.push_back(mkv(4'd9, 32'h5000, 32'h0, 32'h0, 32'hDEAD_BEEF, 5'd11, 1, 1, 0, 2,
                          mkexp(1, 0, 4'h0, 32'h0, 32'hDEAD_BEEF, 1, 0, 1, 1)));
        tbl.push_back(mkv(4'd10, 32'h5000, 32'h77, 32'h0, 32'h0, 5'd12, 1, 1, 1, 2,
                          mkexp(1, 1, 4'hF, 32'h77, 32'h1, 1, 0, 1, 0)));
        tbl.push_back(mkv(4'd2, 32'h6002, 32'h0, 32'h0, 32'h8001_7FFF, 5'd13, 1, 0, 0, 1,
                          mkexp(1, 0, 4'h0, 32'h0, 32'hFFFF_8001, 1, 0, 0, 0)));
        tbl.push_back(mkv(4'd5, 32'h6000, 32'h0, 32'h0, 32'h8001_7FFF, 5'd14, 1, 0, 3, 1,
                          mkexp(1, 0, 4'h0, 32'h0, 32'h0000_7FFF, 1, 0, 0, 0)));
        tbl.push_back(mkv(4'd6, 32'h7001, 32'h1234_565A, 32'h0, 32'h0, 5'd15, 1, 0, 0, 1,
                          mkexp(1, 1, 4'b0010, 32'h5A5A_5A5A, 32'h0, 0, 0, 0, 0)));
        tbl.push_back(mkv(4'd2, 32'h6003, 32'h0, 32'h0, 32'h0, 5'd16, 1, 0, 0, 1,
                          mkexp(0, 0, 4'h0, 32'h0, 32'h6003, 0, 1, 0, 0)));
        tbl.push_back(mkv(4'd15, 32'h0, 32'h0, 32'hCAFE_F00D, 32'h0, 5'd17, 0, 0, 0, 1,
                          mkexp(0, 0, 4'h0, 32'h0, 32'hCAFE_F00D, 0, 0, 0, 0)));

        foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 150; i++) begin
            v.op = 4'($urandom_range(0, 15)); v.addr = $urandom; v.sdata = $urandom;
            v.alu = $urandom; v.rdata = $urandom; v.wd = 5'($urandom);
            v.wreg = 1'($urandom); v.llbit = 1'($urandom);
            v.a_dly = int'($urandom_range(0, 3)); v.d_dly = int'($urandom_range(1, 3));
            v.e = model(v.op, v.addr, v.sdata, v.alu, v.rdata, v.wreg, v.llbit);
            run_op(v, $sformatf("rnd%0d", i));
        end

        // flush in WAIT -> DRAIN, no result, then normal accept
        start_ldw(32'h100);
        data_addr_ok = 1; @(negedge clk); data_addr_ok = 0;
        flush = 1; @(negedge clk); flush = 0;
        for (int i = 0; i < 3; i++) begin
            chk("drain.stall", 32'(stall_req), 32'd1);
            chk("drain.novalid", 32'(mem_valid), 32'd0);
            chk("drain.noreq", 32'(data_req), 32'd0);
            if (i < 2) @(negedge clk);
        end
        data_data_ok = 1; @(negedge clk); data_data_ok = 0;
        chk("drain.exit_stall", 32'(stall_req), 32'd0);
        chk("drain.exit_valid", 32'(mem_valid), 32'd0);
        run_op(tbl[0], "after_drain");

        // flush in REQ without addr_ok -> IDLE, request dropped
        start_ldw(32'h200);
        flush = 1; @(negedge clk); flush = 0;
        chk("reqflush.req", 32'(data_req), 32'd0);
        chk("reqflush.stall", 32'(stall_req), 32'd0);
        chk("reqflush.valid", 32'(mem_valid), 32'd0);

        // flush coincident with addr_ok -> DRAIN
        start_ldw(32'h300);
        flush = 1; data_addr_ok = 1; @(negedge clk); flush = 0; data_addr_ok = 0;
        chk("reqokflush.stall", 32'(stall_req), 32'd1);
        data_data_ok = 1; @(negedge clk); data_data_ok = 0;
        chk("reqokflush.stall_end", 32'(stall_req), 32'd0);
        chk("reqokflush.valid", 32'(mem_valid), 32'd0);

        // flush coincident with data_ok in WAIT -> IDLE without result
        start_ldw(32'h400);
        data_addr_ok = 1; @(negedge clk); data_addr_ok = 0;
        flush = 1; data_data_ok = 1; @(negedge clk); flush = 0; data_data_ok = 0;
        chk("waitokflush.valid", 32'(mem_valid), 32'd0);
        chk("waitokflush.stall", 32'(stall_req), 32'd0);

        // flush in IDLE blocks accept
        ex_valid = 1; ex_mem_op = 0; ex_wdata = 32'h1111; flush = 1;
        @(negedge clk); ex_valid = 0; flush = 0;
        chk("idleflush.valid", 32'(mem_valid), 32'd0);

        // no accept on the edge a result leaves WAIT; accepted one cycle later
        start_ldw(32'h500);
        data_addr_ok = 1; @(negedge clk); data_addr_ok = 0;
        data_data_ok = 1; data_rdata = 32'h0BAD_F00D;
        ex_valid = 1; ex_mem_op = 0; ex_wdata = 32'hBEEF; ex_wd = 5'd3;
        @(negedge clk); data_data_ok = 0;
        chk("b2b.load_valid", 32'(mem_valid), 32'd1);
        chk("b2b.load_data", mem_wdata, 32'h0BAD_F00D);
        @(negedge clk); ex_valid = 0;
        chk("b2b.next_valid", 32'(mem_valid), 32'd1);
        chk("b2b.next_data", mem_wdata, 32'hBEEF);
        @(negedge clk);
        chk("b2b.single", 32'(mem_valid), 32'd0);

        // async reset in REQ drops data_req immediately
        start_ldw(32'h600);
        chk("arst.req_before", 32'(data_req), 32'd1);
        #2 rst = 1;
        #1 chk("arst.req", 32'(data_req), 32'd0);
        chk("arst.stall", 32'(stall_req), 32'd0);
        @(negedge clk); rst = 0;
        @(negedge clk);
        chk("arst.idle_req", 32'(data_req), 32'd0);
        run_op(tbl[4], "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
